// File: rtl/fp32_addsub_arbiter.sv
// fp32_addsub_arbiter: round-robin sharing of one mantissa add/sub unit among
// N_REQ requesters. Grants one eligible requester per cycle, tracks the owner
// of every issued operation in a tag pipeline aligned with the unit latency,
// and steers returning results into one-deep per-requester result buffers.
module fp32_addsub_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 1,
    parameter int IDX_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_signA,
    input  logic [N_REQ-1:0]     req_signB,
    input  logic [24*N_REQ-1:0]  req_mantise_M,
    input  logic [24*N_REQ-1:0]  req_mantise_m,
    output logic [N_REQ-1:0]     res_valid,
    input  logic [N_REQ-1:0]     res_ready,
    output logic [N_REQ-1:0]     res_sign,
    output logic [25*N_REQ-1:0]  res_value,
    output logic                 au_valid_in,
    output logic                 au_signA,
    output logic                 au_signB,
    output logic [23:0]          au_mantise_M,
    output logic [23:0]          au_mantise_m,
    input  logic                 au_valid_out,
    input  logic                 au_sign,
    input  logic [24:0]          au_adder_value,
    output logic                 err
);

    logic [N_REQ-1:0]              pending_q, pending_d;
    logic [N_REQ-1:0]              res_valid_q, res_valid_d;
    logic [N_REQ-1:0]              res_sign_q, res_sign_d;
    logic [25*N_REQ-1:0]           res_value_q, res_value_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0]            tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic                          err_q, err_d;
    logic                          hold_signA_q, hold_signA_d;
    logic                          hold_signB_q, hold_signB_d;
    logic [23:0]                   hold_M_q, hold_M_d;
    logic [23:0]                   hold_m_q, hold_m_d;

    logic [N_REQ-1:0]              elig_s;
    logic [N_REQ-1:0]              grant_s;
    logic                          found_s;
    logic [IDX_W-1:0]              gidx_s;
    int                            cand_s;
    int                            gi_s;
    logic                          tail_vld_s;
    logic [IDX_W-1:0]              tail_idx_s;
    int                            ti_s;
    logic                          ret_s;

    // Round-robin pick of the first eligible requester at or after rr_ptr;
    // eligibility is masked during reset so no grant can leak out.
    always_comb begin
        elig_s  = req_valid & ~pending_q & ~res_valid_q & {N_REQ{~rst}};
        found_s = 1'b0;
        gidx_s  = '0;
        cand_s  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found_s && elig_s[IDX_W'(cand_s)]) begin
                found_s = 1'b1;
                gidx_s  = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        grant_s = '0;
        if (found_s) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Operand mux to the shared unit; without a grant the last issued
    // operands are replayed from registers so the unit inputs stay quiet.
    always_comb begin
        gi_s = int'(gidx_s);
        if (found_s) begin
            au_signA     = req_signA[gidx_s];
            au_signB     = req_signB[gidx_s];
            au_mantise_M = req_mantise_M[gi_s*24 +: 24];
            au_mantise_m = req_mantise_m[gi_s*24 +: 24];
        end else begin
            au_signA     = hold_signA_q;
            au_signB     = hold_signB_q;
            au_mantise_M = hold_M_q;
            au_mantise_m = hold_m_q;
        end
        hold_signA_d = au_signA;
        hold_signB_d = au_signB;
        hold_M_d     = au_mantise_M;
        hold_m_d     = au_mantise_m;
    end

    // Next state: tag shift, result capture, drain, pending and pointer update.
    always_comb begin
        tail_vld_s  = tag_vld_q[LATENCY-1];
        tail_idx_s  = tag_idx_q[LATENCY-1];
        ti_s        = int'(tail_idx_s);
        ret_s       = au_valid_out & tail_vld_s;
        err_d       = err_q | (au_valid_out ^ tail_vld_s);

        tag_vld_d   = tag_vld_q;
        tag_idx_d   = tag_idx_q;
        for (int s = LATENCY - 1; s > 0; s--) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
        tag_vld_d[0] = found_s;
        tag_idx_d[0] = gidx_s;

        pending_d   = pending_q;
        res_valid_d = res_valid_q & ~res_ready;
        res_sign_d  = res_sign_q;
        res_value_d = res_value_q;
        rr_ptr_d    = rr_ptr_q;

        if (found_s) begin
            pending_d[gidx_s] = 1'b1;
            if (gidx_s == IDX_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gidx_s + IDX_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (ret_s) begin
            pending_d[tail_idx_s]        = 1'b0;
            res_valid_d[tail_idx_s]      = 1'b1;
            res_sign_d[tail_idx_s]       = au_sign;
            res_value_d[ti_s*25 +: 25]   = au_adder_value;
        end else begin
            res_sign_d = res_sign_d;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            res_valid_q  <= '0;
            res_sign_q   <= '0;
            res_value_q  <= '0;
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            tag_idx_q    <= '0;
            err_q        <= 1'b0;
            hold_signA_q <= 1'b0;
            hold_signB_q <= 1'b0;
            hold_M_q     <= 24'h000000;
            hold_m_q     <= 24'h000000;
        end else begin
            pending_q    <= pending_d;
            res_valid_q  <= res_valid_d;
            res_sign_q   <= res_sign_d;
            res_value_q  <= res_value_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_idx_q    <= tag_idx_d;
            err_q        <= err_d;
            hold_signA_q <= hold_signA_d;
            hold_signB_q <= hold_signB_d;
            hold_M_q     <= hold_M_d;
            hold_m_q     <= hold_m_d;
        end
    end

    assign req_ready   = grant_s;
    assign au_valid_in = found_s;
    assign res_valid   = res_valid_q;
    assign res_sign    = res_sign_q;
    assign res_value   = res_value_q;
    assign err         = err_q;

endmodule

// File: doc/fp32_addsub_arbiter.md
# fp32_addsub_arbiter

Round-robin arbiter and scheduler that shares one `adder_sub_for_floating_point32` mantissa add/sub unit among `N_REQ` requesters in the FP32 datapath. It accepts one operand set per cycle from the winning requester and drives the shared unit. It tracks the in-flight owner of each issued operation and steers each returned result into that requester's one-deep result buffer. Buffers drain through a valid/ready handshake.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 1: shared unit latency in cycles, from `au_valid_in` sampled to `au_valid_out` high. Range 1..4.
- `IDX_W`, `$clog2(N_REQ)`: requester index width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  N_REQ  operation request, one bit per requester.
- `req_ready`  out  N_REQ  grant; a handshake occurs when `req_valid[i]` and `req_ready[i]` are both high at the edge.
- `req_signA`, `req_signB`  in  N_REQ each  operand signs per requester.
- `req_mantise_M`, `req_mantise_m`  in  24*N_REQ each  mantissas; requester i occupies bits [24i+23:24i].
- `res_valid`  out  N_REQ  result buffer full.
- `res_ready`  in  N_REQ  requester consumes its result.
- `res_sign`  out  N_REQ  result sign per requester.
- `res_value`  out  25*N_REQ  result magnitude; requester i occupies bits [25i+24:25i].
- `au_valid_in`  out  1  issue to the shared unit.
- `au_signA`, `au_signB`  out  1 each  signs to the unit.
- `au_mantise_M`, `au_mantise_m`  out  24 each  mantissas to the unit.
- `au_valid_out`  in  1  unit result valid.
- `au_sign`  in  1  unit result sign.
- `au_adder_value`  in  25  unit result magnitude.
- `err`  out  1  sticky protocol-error flag.

## Operation
- **Per-requester state:**
  - `pending[i]`: operation in flight.
  - Result buffer: `res_valid[i]`, `res_sign[i]`, `res_value[i]`.
- **Eligibility:** `elig[i] = req_valid[i] & ~pending[i] & ~res_valid[i]`. A requester never has more than one operation outstanding, so every returning result finds an empty buffer. The unit has no backpressure, and none is needed.
- **Arbitration (combinational):**
  - Round-robin over `elig`, starting at pointer `rr_ptr`.
  - `req_ready` is one-hot or zero, and `req_ready[i]` implies `elig[i]`.
  - `req_ready` may depend on `req_valid`.
- **Issue:**
  - `au_valid_in = |req_ready`.
  - `au_*` operands are muxed combinationally from the granted requester.
  - When there is no grant, the operands are held at the last issued values (registered copies, so they do not glitch into the unit).
- **On grant to index g:**
  - `pending[g] <= 1`.
  - `rr_ptr <= (g+1) mod N_REQ`.
  - `{1, g}` is pushed into the tag pipeline.
- **Tag pipeline:** `LATENCY` stages of `{vld, idx}`, shifting every cycle, with bubbles entering as `vld = 0`. The tail stage aligns with `au_valid_out`.
- **Return, `au_valid_out` = 1 with tail `vld` = 1, index t:**
  - `res_sign[t] <= au_sign`.
  - `res_value[t] <= au_adder_value`.
  - `res_valid[t] <= 1`.
  - `pending[t] <= 0`.
- **Drain:** `res_valid[i] & res_ready[i]` at the edge clears `res_valid[i]`. `res_sign` and `res_value` hold their values.
- **Protocol errors:** `err` sets if `au_valid_out` ≠ tail `vld`. The result is then dropped and state is unchanged. `err` clears only on `rst`.
- **Simultaneous return and drain on the same requester:** cannot occur, because a return implies `pending[i]`, which implies `~res_valid[i]`.
- **Width rules:** 25-bit results pass through unmodified; no normalisation is performed here.

## Timing
- **Reset values:** `req_ready` 0, `res_valid` 0, `res_sign` 0, `res_value` 0, all `au_*` 0, `err` 0, `rr_ptr` 0, `pending` 0, tag pipeline empty.
- **Reset during operation:** in-flight operations are discarded. The shared unit must be reset by the same `rst` source, so that no stale `au_valid_out` arrives after reset.
- **Accept at edge E:**
  - The unit samples at E.
  - `au_valid_out` is high in cycle E+LATENCY.
  - `res_valid` is high from edge E+LATENCY+1.
  - For LATENCY = 1, that is 2 cycles from accept to `res_valid`.
- **Re-grant:** a requester can be re-granted at the earliest one cycle after its buffer drains.
- **Throughput:**
  - Aggregate: 1 operation per cycle when at least LATENCY+2 requesters are active.
  - Single requester: 1 per LATENCY+2 cycles.
- **Fairness:** a requester waits at most N_REQ−1 grants once it is eligible.

## Test plan
- **Single add:** requester 0 issues `signA` = `signB` = 0, M = 0x800000, m = 0x400000 (real unit attached).
  - Expect `au_valid_in` in the accept cycle.
  - Expect `res_valid[0]` 2 cycles later with value 0x0C00000 and sign 0.
  - Expect `req_ready[0]` low until drained.
- **Subtract with swap:** requester 1 issues `signA` = 0, `signB` = 1, M = 0x400000, m = 0x800000.
  - Expect `res_value[1]` = 0x0400000 and `res_sign[1]` = 1.
  - Expect the other buffers untouched.
- **Round-robin:** all 4 requesters hold `req_valid` and drain immediately.
  - Expect grant order 0, 1, 2, 3, 0, ….
  - Expect `au_valid_in` high every cycle after the first.
  - Expect each result routed to its own index.
- **Backpressure:** requester 2 holds `res_ready` = 0 with `req_valid` high.
  - Expect no second grant to 2 and the result held stable.
  - Requesters 0, 1 and 3 continue to be served.
  - After `res_ready` pulses, expect a grant to 2 one cycle later.
- **Reset mid-flight:** assert `rst` for 1 cycle while 3 operations are in flight.
  - Expect all outputs to return to their reset values immediately.
  - Expect no `res_valid` afterwards and `err` = 0.
- **Protocol error:** force `au_valid_out` = 1 with an empty tag pipeline.
  - Expect `err` = 1 from the next edge, sticky.
  - Expect `res_valid` unchanged.
